// File: rtl/seq_mult_pkg.sv
// Shared types for the 24x24 sequential multiplier: FSM states, partial-product
// steps, per-step shift table and zero-skip step selection helpers.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } state_t;

  // Step index doubles as the bit position in the zero-skip need mask.
  typedef enum logic [1:0] {
    STEP_LL,
    STEP_LH,
    STEP_HL,
    STEP_HH
  } step_t;

  // Shift per step, in units of HALF_W.
  function automatic logic [1:0] step_shift_halves(input step_t s);
    case (s)
      STEP_LL: return 2'd0;
      STEP_LH: return 2'd1;
      STEP_HL: return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  // Bit set for each step whose partial product can be non-zero.
  function automatic logic [3:0] need_mask(input logic al_nz, input logic ah_nz,
                                           input logic bl_nz, input logic bh_nz);
    return {ah_nz & bh_nz, ah_nz & bl_nz, al_nz & bh_nz, al_nz & bl_nz};
  endfunction

  // Lowest needed step index >= from; 4 when none remain.
  function automatic logic [2:0] next_step(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mult_half_mul.sv
// Combinational HALF_W x HALF_W -> 2*HALF_W unsigned multiplier shared by all steps.
module seq_mult_half_mul #(
  parameter int unsigned HALF_W = 12
) (
  input  logic [HALF_W-1:0]   x,
  input  logic [HALF_W-1:0]   y,
  output logic [2*HALF_W-1:0] prod_c
);
  localparam int unsigned PW = 2 * HALF_W;

  assign prod_c = PW'(x) * PW'(y);
endmodule

// File: rtl/seq_mult24_ctrl.sv
// Sequencer for DATA_W x DATA_W unsigned multiply via four half-width partial products.
// Optional build macro ZERO_SKIP_EN skips steps whose partial product is provably zero.
module seq_mult24_ctrl
  import seq_mult_pkg::*;
#(
  parameter int unsigned DATA_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] p,
  output logic                busy
);
  localparam int unsigned HALF_W = DATA_W / 2;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SH_W   = $clog2(PROD_W);

  state_t              state, state_nxt;
  step_t               step, step_nxt;
  logic [DATA_W-1:0]   op_a, op_b, op_a_nxt, op_b_nxt;
  logic [PROD_W-1:0]   acc, acc_nxt, acc_sum, p_nxt;
  logic [HALF_W-1:0]   mul_x, mul_y;
  logic [2*HALF_W-1:0] pp;
  logic [SH_W-1:0]     shamt;
  logic                last_step;
`ifdef ZERO_SKIP_EN
  logic [3:0]          need, need_nxt;
  logic [2:0]          skip_idx;
`endif

  // Half-select muxes feeding the single shared multiplier.
  always_comb begin
    mul_x = op_a[HALF_W-1:0];
    mul_y = op_b[HALF_W-1:0];
    case (step)
      STEP_LH: mul_y = op_b[DATA_W-1:HALF_W];
      STEP_HL: mul_x = op_a[DATA_W-1:HALF_W];
      STEP_HH: begin
        mul_x = op_a[DATA_W-1:HALF_W];
        mul_y = op_b[DATA_W-1:HALF_W];
      end
      default: ;
    endcase
  end

  seq_mult_half_mul #(.HALF_W(HALF_W)) u_half_mul (
    .x      (mul_x),
    .y      (mul_y),
    .prod_c (pp)
  );

  assign shamt   = SH_W'(HALF_W) * SH_W'(step_shift_halves(step));
  assign acc_sum = acc + (PROD_W'(pp) << shamt);

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    op_a_nxt  = op_a;
    op_b_nxt  = op_b;
    acc_nxt   = acc;
    p_nxt     = p;
    last_step = 1'b0;
`ifdef ZERO_SKIP_EN
    need_nxt  = need;
    skip_idx  = 3'd4;
`endif
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          op_a_nxt = a;
          op_b_nxt = b;
          acc_nxt  = '0;
`ifdef ZERO_SKIP_EN
          need_nxt = need_mask(|a[HALF_W-1:0], |a[DATA_W-1:HALF_W],
                               |b[HALF_W-1:0], |b[DATA_W-1:HALF_W]);
          skip_idx = next_step(need_nxt, 3'd0);
          if (skip_idx[2]) begin
            state_nxt = ST_DONE;
            step_nxt  = STEP_LL;
            p_nxt     = '0;
          end else begin
            state_nxt = ST_MUL;
            step_nxt  = step_t'(skip_idx[1:0]);
          end
`else
          state_nxt = ST_MUL;
          step_nxt  = STEP_LL;
`endif
        end
      end
      ST_MUL: begin
        acc_nxt = acc_sum;
`ifdef ZERO_SKIP_EN
        skip_idx  = next_step(need, 3'(step) + 3'd1);
        last_step = skip_idx[2];
        if (!last_step) step_nxt = step_t'(skip_idx[1:0]);
`else
        last_step = (step == STEP_HH);
        if (!last_step) step_nxt = step_t'(step + 2'd1);
`endif
        if (last_step) begin
          state_nxt = ST_DONE;
          p_nxt     = acc_sum;
        end
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      step      <= STEP_LL;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      p         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ZERO_SKIP_EN
      need      <= '0;
`endif
    end else begin
      state     <= state_nxt;
      step      <= step_nxt;
      op_a      <= op_a_nxt;
      op_b      <= op_b_nxt;
      acc       <= acc_nxt;
      p         <= p_nxt;
      in_ready  <= (state_nxt == ST_IDLE);
      out_valid <= (state_nxt == ST_DONE);
      busy      <= (state_nxt != ST_IDLE);
`ifdef ZERO_SKIP_EN
      need      <= need_nxt;
`endif
    end
  end

endmodule
